// File: rtl/data_cache_wt_pkg.sv
// Shared types and constants for the write-through data cache.
package data_cache_wt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } dcache_state_t;

  localparam logic [3:0] BLE_BYTE = 4'b0001;
  localparam logic [3:0] BLE_HALF = 4'b0011;
  localparam logic [3:0] BLE_WORD = 4'b1111;
  localparam logic [3:0] BLE_NONE = 4'b0000;

endpackage

// File: rtl/data_cache_wt_lane_align.sv
// Byte-lane positioning between the pipeline's right-aligned data and
// the word-organised cache/memory. Lanes pushed past bit 3 fall off, so a
// misaligned access simply loses its upper bytes instead of wrapping.
module data_cache_wt_lane_align (
  input  logic [1:0]  i_offset,
  input  logic [3:0]  i_ble,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_lanes,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  assign o_lanes = i_ble << i_offset;
  assign o_wdata = i_wdata << {i_offset, 3'b000};
  assign o_rdata = i_rword >> {i_offset, 3'b000};

endmodule

// File: rtl/data_cache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM
// stage. Loads hit with zero penalty; misses refill a whole line word by
// word; every store goes to memory and stalls until the memory acks it.
// Handshake: mem_req_o and all mem_* outputs are registered and held until
// the single-cycle mem_ack_i pulse; validity_o low means the pipeline stalls
// and the request inputs stay stable until validity_o returns high.
module data_cache_wt
  import data_cache_wt_pkg::*;
#(
  parameter int NB_LINES   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  ble_i,
  input  logic        write_i,
  output logic [31:0] read_data_o,
  output logic        validity_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NB_LINES);
  localparam int TB = 30 - WB - IB;

  logic [WB-1:0]  w_word;
  logic [IB-1:0]  w_idx;
  logic [TB-1:0]  w_tag;
  logic [31:0]    w_rword;
  logic           w_hit;
  logic           w_access;
  logic [3:0]     w_lanes;
  logic [31:0]    w_wdata_sh;
  logic [31:0]    w_rdata_sh;

  logic [31:0]    r_data [NB_LINES*LINE_WORDS];
  logic [TB-1:0]  r_tag [NB_LINES];
  logic [NB_LINES-1:0] r_valid;
  dcache_state_t  r_state;
  logic [WB-1:0]  r_cnt;

  assign w_word   = addr_i[2 +: WB];
  assign w_idx    = addr_i[2+WB +: IB];
  assign w_tag    = addr_i[31 -: TB];
  assign w_rword  = r_data[{w_idx, w_word}];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_access = (ble_i != BLE_NONE);

  data_cache_wt_lane_align u_align (
    .i_offset (addr_i[1:0]),
    .i_ble    (ble_i),
    .i_wdata  (write_data_i),
    .i_rword  (w_rword),
    .o_lanes  (w_lanes),
    .o_wdata  (w_wdata_sh),
    .o_rdata  (w_rdata_sh)
  );

  assign read_data_o = w_rdata_sh;

  // Completion flag: free when idle with nothing to do or a load hit, and
  // a store completes only in the cycle its write is acknowledged.
  always_comb begin
    validity_o = 1'b0;
    if (r_state == IDLE)
      validity_o = !w_access || (!write_i && w_hit);
    else if (r_state == WRITE)
      validity_o = mem_ack_i;
  end

  // Controller FSM, line storage and registered memory-port outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_valid     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      for (int i = 0; i < NB_LINES*LINE_WORDS; i++) r_data[i] <= '0;
      for (int i = 0; i < NB_LINES; i++) r_tag[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access && write_i) begin
            r_state     <= WRITE;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_wdata_o <= w_wdata_sh;
            mem_be_o    <= w_lanes;
            if (w_hit) begin
              for (int b = 0; b < 4; b++)
                if (w_lanes[b])
                  r_data[{w_idx, w_word}][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
          end else if (w_access && !w_hit) begin
            r_state        <= REFILL;
            r_cnt          <= '0;
            r_valid[w_idx] <= 1'b0;
            mem_req_o      <= 1'b1;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= {w_tag, w_idx, {WB{1'b0}}, 2'b00};
            mem_wdata_o    <= '0;
            mem_be_o       <= 4'b1111;
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            r_data[{w_idx, r_cnt}] <= mem_rdata_i;
            if (r_cnt == WB'(LINE_WORDS - 1)) begin
              r_tag[w_idx]   <= w_tag;
              r_valid[w_idx] <= 1'b1;
              r_state        <= IDLE;
              r_cnt          <= '0;
              mem_req_o      <= 1'b0;
              mem_addr_o     <= '0;
              mem_be_o       <= '0;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              mem_addr_o <= {w_tag, w_idx, r_cnt + 1'b1, 2'b00};
            end
          end
        end
        WRITE: begin
          if (mem_ack_i) begin
            r_state     <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_wt.sv
// Bench for data_cache_wt: directed scenarios plus a short random mix,
// with a reference memory, a tag model and expected queues for both the
// load results and the memory-port transactions.
module tb_data_cache_wt;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [3:0]  ble_i;
  logic        write_i;
  logic [31:0] read_data_o;
  logic        validity_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  data_cache_wt dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .ble_i        (ble_i),
    .write_i      (write_i),
    .read_data_o  (read_data_o),
    .validity_o   (validity_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [3:0]  exp_be_q[$];
  logic [31:0] exp_wd_q[$];
  logic        exp_we_q[$];

  logic [31:0] bmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [21:0] m_tag   [64];
  logic        m_valid [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_bmem(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // memory responder for the current cycle: acks any pending request
  task automatic serve();
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        ewe;
    if (exp_addr_q.size() == 0) begin
      check("unexpected_req", mem_addr_o, 32'hDEAD_BEEF ^ mem_addr_o);
    end else begin
      ea = exp_addr_q.pop_front();
      eb = exp_be_q.pop_front();
      ew = exp_wd_q.pop_front();
      ewe = exp_we_q.pop_front();
      check("mem_addr", mem_addr_o, ea);
      check("mem_we", {31'd0, mem_we_o}, {31'd0, ewe});
      check("mem_be", {28'd0, mem_be_o}, {28'd0, eb});
      if (ewe) check("mem_wdata", mem_wdata_o, ew);
    end
    if (mem_we_o) bmem[mem_addr_o] = merge(rd_bmem(mem_addr_o), mem_wdata_o, mem_be_o);
    else mem_rdata_i = rd_bmem(mem_addr_o);
  endtask

  // driver: present one access and run it to completion
  task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ble,
                            input logic we, input int exp_cyc, input logic chk_rd);
    int  cyc;
    bit  done;
    @(negedge clk_i);
    addr_i = a; write_data_i = wd; ble_i = ble; write_i = we;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      mem_ack_i = mem_req_o;
      if (mem_req_o) serve();
      #1;
      if (validity_o) begin
        done = 1;
        if (chk_rd) check("read_data", read_data_o, exp_q.pop_front());
      end else begin
        cyc++;
        @(negedge clk_i);
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check("stall_cycles", cyc, exp_cyc);
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    ble_i = 4'b0000;
    write_i = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] ble);
    logic [5:0]  idx;
    logic [21:0] tg;
    int cyc;
    idx = a[9:4];
    tg  = a[31:10];
    cyc = 0;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      for (int w = 0; w < 4; w++) begin
        exp_addr_q.push_back({a[31:4], 4'b0000} + 32'(4*w));
        exp_be_q.push_back(4'b1111);
        exp_wd_q.push_back(32'd0);
        exp_we_q.push_back(1'b0);
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      cyc = 5;
    end
    exp_q.push_back(rd_ref({a[31:2], 2'b00}) >> (8 * a[1:0]));
    run_access(a, 32'd0, ble, 1'b0, cyc, 1'b1);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ble);
    logic [3:0]  lanes;
    logic [31:0] wsh;
    logic [7:0]  lx;
    lx    = {4'b0000, ble} << a[1:0];
    lanes = lx[3:0];
    wsh   = d << (8 * a[1:0]);
    exp_addr_q.push_back({a[31:2], 2'b00});
    exp_be_q.push_back(lanes);
    exp_wd_q.push_back(wsh);
    exp_we_q.push_back(1'b1);
    ref_mem[{a[31:2], 2'b00}] = merge(rd_ref({a[31:2], 2'b00}), wsh, lanes);
    run_access(a, d, ble, 1'b1, 1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_validity"}, {31'd0, validity_o}, 32'd1);
    check({tag, "_mem_req"}, {31'd0, mem_req_o}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we_o}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    check({tag, "_mem_be"}, {28'd0, mem_be_o}, 32'd0);
    check({tag, "_read_data"}, read_data_o, 32'd0);
  endtask

  logic [31:0] bases [3];

  initial begin
    rst_i = 1'b0;
    addr_i = 32'h100; write_data_i = 0; ble_i = 0; write_i = 0;
    mem_rdata_i = 0; mem_ack_i = 0;
    for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_tag[i] = '0; end
    bmem[32'h100] = 32'h11111111; ref_mem[32'h100] = 32'h11111111;
    bmem[32'h104] = 32'h22222222; ref_mem[32'h104] = 32'h22222222;
    bmem[32'h108] = 32'h33333333; ref_mem[32'h108] = 32'h33333333;
    bmem[32'h10C] = 32'h44444444; ref_mem[32'h10C] = 32'h44444444;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("reset");

    // idle, no access
    run_access(32'h100, 32'd0, 4'b0000, 1'b0, 0, 1'b0);

    // cold load, hit, store hit, half load
    do_load(32'h100, 4'b1111);
    do_load(32'h108, 4'b1111);
    check("literal_hit_0x108", rd_ref(32'h108), 32'h33333333);
    do_store(32'h10A, 32'h000000AB, 4'b0001);
    do_load(32'h10A, 4'b0011);
    check("literal_half_0x10A", rd_ref(32'h108) >> 16, 32'h000033AB);

    // store miss (no allocate), then load refills
    do_store(32'h2000, 32'hCAFEF00D, 4'b1111);
    do_load(32'h2000, 4'b1111);

    // conflict on the same index
    do_load(32'h100, 4'b1111);
    do_load(32'h500, 4'b1111);
    do_load(32'h100, 4'b1111);

    // reset during the third refill word of a conflicting miss
    @(negedge clk_i);
    addr_i = 32'h900; ble_i = 4'b1111; write_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      exp_addr_q.push_back(32'h900 + 32'(4*w));
      exp_be_q.push_back(4'b1111);
      exp_wd_q.push_back(32'd0);
      exp_we_q.push_back(1'b0);
    end
    begin
      int acks;
      int guard;
      acks = 0;
      guard = 0;
      while (!(mem_req_o && acks == 2) && guard < 20) begin
        mem_ack_i = mem_req_o;
        if (mem_req_o) begin serve(); acks++; end
        @(negedge clk_i);
        guard++;
      end
      if (guard >= 20) check("rst_mid_timeout", 32'd0, 32'd1);
    end
    mem_ack_i = 1'b0;
    check("third_word_addr", mem_addr_o, 32'h908);
    ble_i = 4'b0000;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    do_load(32'h100, 4'b1111);

    // random mix of sizes and stores/loads over three conflicting tags
    bases[0] = 32'h0000_0100;
    bases[1] = 32'h0000_0500;
    bases[2] = 32'h0000_0900;
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      logic [3:0]  ble;
      int sz;
      sz = $urandom_range(0, 2);
      a  = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 3) * 4);
      if (sz == 0) begin ble = 4'b0001; a = a + 32'($urandom_range(0, 3)); end
      else if (sz == 1) begin ble = 4'b0011; a = a + 32'($urandom_range(0, 1) * 2); end
      else ble = 4'b1111;
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] d;
        d = $urandom();
        if (sz == 0) d = d & 32'h0000_00FF;
        else if (sz == 1) d = d & 32'h0000_FFFF;
        do_store(a, d, ble);
      end else begin
        do_load(a, ble);
      end
    end

    check("leftover_mem_ops", exp_addr_q.size(), 0);
    check("leftover_loads", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
